// File: rtl/cmd_pkg.sv
// =============================================================================
// Module      : cmd_pkg
// Description : Shared command indices, sequencer state encoding and CRC
//               coverage masks for the command sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cmd_pkg;

    localparam int unsigned CMD_NCMD = 13;

    localparam logic [3:0] CMD_QUERYREP   = 4'd0;
    localparam logic [3:0] CMD_ACK        = 4'd1;
    localparam logic [3:0] CMD_QUERY      = 4'd2;
    localparam logic [3:0] CMD_QUERYADJ   = 4'd3;
    localparam logic [3:0] CMD_SELECT     = 4'd4;
    localparam logic [3:0] CMD_NAK        = 4'd5;
    localparam logic [3:0] CMD_REQ_RN     = 4'd6;
    localparam logic [3:0] CMD_READ       = 4'd7;
    localparam logic [3:0] CMD_WRITE      = 4'd8;
    localparam logic [3:0] CMD_KILL       = 4'd9;
    localparam logic [3:0] CMD_LOCK       = 4'd10;
    localparam logic [3:0] CMD_SENSOR_RD1 = 4'd11;
    localparam logic [3:0] CMD_SENSOR_RD2 = 4'd12;
    localparam logic [3:0] CMD_NONE       = 4'hF;

    // Commands whose packets are only trusted when the matching CRC passed
    localparam logic [CMD_NCMD-1:0] CRC5_MASK  = 13'h0004;
    localparam logic [CMD_NCMD-1:0] CRC16_MASK = 13'h09D0;

    typedef enum logic [2:0] {
        ST_RECOVER   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RECV      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DISPATCH  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_onehot_enc.sv
// =============================================================================
// Module      : cmd_onehot_enc
// Description : Combinational one-hot to index encoder; o_valid only when
//               exactly one input bit is set, otherwise index is CMD_NONE.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cmd_onehot_enc
    import cmd_pkg::*;
#(
    parameter int unsigned NCMD = 13
) (
    input  logic [NCMD-1:0] i_cmd,
    output logic [3:0]      o_idx,
    output logic            o_valid
);

    logic [1:0] w_hits;
    logic [3:0] w_idx;

    // Hit count saturates at 2: only "none", "one" and "many" matter
    always_comb begin
        w_hits = 2'd0;
        w_idx  = CMD_NONE;
        for (int i = 0; i < NCMD; i++) begin
            if (i_cmd[i]) begin
                if (w_hits != 2'd2) begin
                    w_hits = w_hits + 2'd1;
                end
                w_idx = 4'(i);
            end
        end
    end

    assign o_valid = (w_hits == 2'd1);
    assign o_idx   = o_valid ? w_idx : CMD_NONE;

endmodule

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// =============================================================================
// Module      : cmd_sequencer
// Description : Parser reset / packet validation / handler dispatch sequencer.
//               Optional drop-cause statistics under `CMD_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cmd_sequencer
    import cmd_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT      = 4095,
    parameter int unsigned HANDLER_TIMEOUT = 1023,
    parameter int unsigned RST_CYCLES      = 4,
    parameter int unsigned NCMD            = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCMD-1:0] cmd_out,
    input  logic            cmd_complete,
    input  logic            packet_complete,
    input  logic            crc5invalid,
    input  logic            crc16invalid,
    input  logic            handler_done,
    output logic            parser_reset,
    output logic            handler_start,
    output logic [3:0]      cmd_id,
    output logic            busy,
    output logic            drop
`ifdef CMD_SEQ_STATS_EN
    ,
    output logic [7:0]      crc_err_cnt,
    output logic [7:0]      rx_to_cnt,
    output logic [7:0]      hdl_to_cnt,
    output logic [7:0]      bad_cmd_cnt
`endif
);

    localparam int unsigned C_RX_W = $clog2(RX_TIMEOUT + 1);
    localparam int unsigned C_HT_W = $clog2(HANDLER_TIMEOUT + 1);
    localparam int unsigned C_RC_W = $clog2(RST_CYCLES + 1);

    state_t            r_state, w_state_nxt;
    logic [C_RC_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
    logic [C_RX_W-1:0] r_rx_wd, w_rx_wd_nxt;
    logic [C_HT_W-1:0] r_hdl_tmr, w_hdl_tmr_nxt;
    logic              r_parser_reset, w_parser_reset_nxt;
    logic              r_handler_start, w_handler_start_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_drop, w_drop_nxt;
    logic [3:0]        r_cmd_id, w_cmd_id_nxt;

    logic [3:0]        w_enc_idx;
    logic              w_enc_valid;
    logic              w_crc_fail;
    logic              w_rx_expire;
    logic              w_hdl_expire;

    cmd_onehot_enc #(
        .NCMD    (NCMD)
    ) u_enc (
        .i_cmd   (cmd_out),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    assign w_crc_fail = (crc5invalid  && (|(cmd_out & NCMD'(CRC5_MASK))))
                     || (crc16invalid && (|(cmd_out & NCMD'(CRC16_MASK))));

    // Expiry is judged on the count including the current cycle
    assign w_rx_expire  = (32'(r_rx_wd)   + 32'd1) >= RX_TIMEOUT;
    assign w_hdl_expire = (32'(r_hdl_tmr) + 32'd1) >= HANDLER_TIMEOUT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_RECOVER;
            r_rst_cnt       <= C_RC_W'(RST_CYCLES);
            r_rx_wd         <= '0;
            r_hdl_tmr       <= '0;
            r_parser_reset  <= 1'b1;
            r_handler_start <= 1'b0;
            r_busy          <= 1'b0;
            r_drop          <= 1'b0;
            r_cmd_id        <= CMD_NONE;
        end else begin
            r_state         <= w_state_nxt;
            r_rst_cnt       <= w_rst_cnt_nxt;
            r_rx_wd         <= w_rx_wd_nxt;
            r_hdl_tmr       <= w_hdl_tmr_nxt;
            r_parser_reset  <= w_parser_reset_nxt;
            r_handler_start <= w_handler_start_nxt;
            r_busy          <= w_busy_nxt;
            r_drop          <= w_drop_nxt;
            r_cmd_id        <= w_cmd_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_rst_cnt_nxt       = r_rst_cnt;
        w_rx_wd_nxt         = r_rx_wd;
        w_hdl_tmr_nxt       = r_hdl_tmr;
        w_parser_reset_nxt  = r_parser_reset;
        w_handler_start_nxt = 1'b0;
        w_busy_nxt          = r_busy;
        w_drop_nxt          = 1'b0;
        w_cmd_id_nxt        = r_cmd_id;

        case (r_state)
            ST_RECOVER: begin
                w_parser_reset_nxt = 1'b1;
                if (r_rst_cnt <= C_RC_W'(1)) begin
                    w_state_nxt        = ST_IDLE;
                    w_parser_reset_nxt = 1'b0;
                    w_rst_cnt_nxt      = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - C_RC_W'(1);
                end
            end

            ST_IDLE: begin
                if (cmd_complete) begin
                    w_rx_wd_nxt = '0;
                    w_state_nxt = packet_complete ? ST_CHECK : ST_RECV;
                end
            end

            ST_RECV: begin
                if (packet_complete) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_rx_expire) begin
                    w_drop_nxt         = 1'b1;
                    w_state_nxt        = ST_RECOVER;
                    w_rst_cnt_nxt      = C_RC_W'(RST_CYCLES);
                    w_parser_reset_nxt = 1'b1;
                end else if (r_rx_wd != '1) begin
                    w_rx_wd_nxt = r_rx_wd + C_RX_W'(1);
                end
            end

            ST_CHECK: begin
                if (!w_enc_valid || w_crc_fail) begin
                    w_drop_nxt         = 1'b1;
                    w_state_nxt        = ST_RECOVER;
                    w_rst_cnt_nxt      = C_RC_W'(RST_CYCLES);
                    w_parser_reset_nxt = 1'b1;
                end else begin
                    w_cmd_id_nxt        = w_enc_idx;
                    w_handler_start_nxt = 1'b1;
                    w_busy_nxt          = 1'b1;
                    w_state_nxt         = ST_DISPATCH;
                end
            end

            ST_DISPATCH: begin
                w_hdl_tmr_nxt = '0;
                w_state_nxt   = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                // A done arriving in the expiry cycle still counts as on time
                if (handler_done || w_hdl_expire) begin
                    w_drop_nxt         = !handler_done;
                    w_busy_nxt         = 1'b0;
                    w_cmd_id_nxt       = CMD_NONE;
                    w_state_nxt        = ST_RECOVER;
                    w_rst_cnt_nxt      = C_RC_W'(RST_CYCLES);
                    w_parser_reset_nxt = 1'b1;
                end else if (r_hdl_tmr != '1) begin
                    w_hdl_tmr_nxt = r_hdl_tmr + C_HT_W'(1);
                end
            end

            default: begin
                w_state_nxt        = ST_RECOVER;
                w_rst_cnt_nxt      = C_RC_W'(RST_CYCLES);
                w_parser_reset_nxt = 1'b1;
                w_busy_nxt         = 1'b0;
                w_cmd_id_nxt       = CMD_NONE;
            end
        endcase
    end

    assign parser_reset  = r_parser_reset;
    assign handler_start = r_handler_start;
    assign cmd_id        = r_cmd_id;
    assign busy          = r_busy;
    assign drop          = r_drop;

`ifdef CMD_SEQ_STATS_EN
    logic [7:0] r_crc_err_cnt;
    logic [7:0] r_rx_to_cnt;
    logic [7:0] r_hdl_to_cnt;
    logic [7:0] r_bad_cmd_cnt;

    logic w_ev_bad, w_ev_crc, w_ev_rx_to, w_ev_hdl_to;

    assign w_ev_bad    = (r_state == ST_CHECK) && !w_enc_valid;
    assign w_ev_crc    = (r_state == ST_CHECK) && w_enc_valid && w_crc_fail;
    assign w_ev_rx_to  = (r_state == ST_RECV) && !packet_complete && w_rx_expire;
    assign w_ev_hdl_to = (r_state == ST_WAIT_DONE) && !handler_done && w_hdl_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_err_cnt <= 8'd0;
            r_rx_to_cnt   <= 8'd0;
            r_hdl_to_cnt  <= 8'd0;
            r_bad_cmd_cnt <= 8'd0;
        end else begin
            if (w_ev_crc)    r_crc_err_cnt <= sat_inc8(r_crc_err_cnt);
            if (w_ev_rx_to)  r_rx_to_cnt   <= sat_inc8(r_rx_to_cnt);
            if (w_ev_hdl_to) r_hdl_to_cnt  <= sat_inc8(r_hdl_to_cnt);
            if (w_ev_bad)    r_bad_cmd_cnt <= sat_inc8(r_bad_cmd_cnt);
        end
    end

    assign crc_err_cnt = r_crc_err_cnt;
    assign rx_to_cnt   = r_rx_to_cnt;
    assign hdl_to_cnt  = r_hdl_to_cnt;
    assign bad_cmd_cnt = r_bad_cmd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// =============================================================================
// Module      : tb_cmd_sequencer
// Description : Scoreboard bench for cmd_sequencer: a driver predicts output
//               events from the packet rules, a monitor matches DUT events.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_cmd_sequencer;

    localparam int RX_T  = 4095;
    localparam int HDL_T = 1023;
    localparam int RSTC  = 4;

    localparam int EV_START = 0;
    localparam int EV_DROP  = 1;
    localparam int EV_BFALL = 2;
    localparam int EV_PFALL = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] id;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] cmd_out = '0;
    logic        cmd_complete = 1'b0;
    logic        packet_complete = 1'b0;
    logic        crc5invalid = 1'b0;
    logic        crc16invalid = 1'b0;
    logic        handler_done = 1'b0;
    logic        parser_reset, handler_start, busy, drop;
    logic [3:0]  cmd_id;
`ifdef CMD_SEQ_STATS_EN
    logic [7:0]  crc_err_cnt, rx_to_cnt, hdl_to_cnt, bad_cmd_cnt;
`endif

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  next_free = 0;
    int  m_crc = 0, m_rx = 0, m_hdl = 0, m_bad = 0;
    ev_t exp_q[$];
    bit  prev_busy = 1'b0;
    bit  prev_pr = 1'b1;

    cmd_sequencer #(
        .RX_TIMEOUT      (RX_T),
        .HANDLER_TIMEOUT (HDL_T),
        .RST_CYCLES      (RSTC),
        .NCMD            (13)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_out         (cmd_out),
        .cmd_complete    (cmd_complete),
        .packet_complete (packet_complete),
        .crc5invalid     (crc5invalid),
        .crc16invalid    (crc16invalid),
        .handler_done    (handler_done),
        .parser_reset    (parser_reset),
        .handler_start   (handler_start),
        .cmd_id          (cmd_id),
        .busy            (busy),
        .drop            (drop)
`ifdef CMD_SEQ_STATS_EN
        ,
        .crc_err_cnt     (crc_err_cnt),
        .rx_to_cnt       (rx_to_cnt),
        .hdl_to_cnt      (hdl_to_cnt),
        .bad_cmd_cnt     (bad_cmd_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input int c, input logic [3:0] id);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing expected", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.id != cmd_id) begin
                n_fail++;
                $display("FAIL event: got kind %0d cyc %0d id %0h, expected kind %0d cyc %0d id %0h",
                         k, cyc, cmd_id, e.kind, e.cyc, e.id);
            end
        end
    endtask

    // Monitor: detects output events in a fixed order each cycle
    always @(negedge clk) begin
        if (handler_start === 1'b1)                  match_ev(EV_START);
        if (drop === 1'b1)                           match_ev(EV_DROP);
        if (prev_busy && busy === 1'b0)              match_ev(EV_BFALL);
        if (prev_pr && parser_reset === 1'b0)        match_ev(EV_PFALL);
        prev_busy = (busy === 1'b1);
        prev_pr   = (parser_reset === 1'b1);
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Reference rules: 0 = dispatch, 1 = bad vector, 2 = crc reject
    function automatic int judge(input logic [12:0] v, input logic c5, input logic c16,
                                 output logic [3:0] idx);
        idx = 4'hF;
        if ($countones(v) != 1) return 1;
        for (int i = 0; i < 13; i++) if (v[i]) idx = 4'(i);
        if (idx == 4'd2 && c5) return 2;
        if ((idx == 4'd4 || idx == 4'd6 || idx == 4'd7 || idx == 4'd8 || idx == 4'd11) && c16)
            return 2;
        return 0;
    endfunction

    // d: cycles from cmd_complete to packet_complete; j: cycles from
    // handler_start to done pulse (outside 1..HDL_T means never sent)
    task automatic send_packet(input logic [12:0] v, input logic c5, input logic c16,
                               input int d, input int j, input bit reset_mid);
        int a, p, s, q, fin, verdict;
        logic [3:0] idx;
        wait_until(next_free);
        cmd_out = v; crc5invalid = c5; crc16invalid = c16; cmd_complete = 1'b1;
        a = cyc;
        if (d > RX_T) begin
            push_ev(EV_DROP, a + RX_T + 1, 4'hF);
            push_ev(EV_PFALL, a + RX_T + 5, 4'hF);
            m_rx++;
            wait_until(a + RX_T + 1);
            cmd_out = '0; cmd_complete = 1'b0; crc5invalid = 1'b0; crc16invalid = 1'b0;
            next_free = a + RX_T + 5 + $urandom_range(0, 2);
            return;
        end
        wait_until(a + d);
        packet_complete = 1'b1;
        p = a + d;
        s = p + 2;
        fin = 0;
        verdict = judge(v, c5, c16, idx);
        if (verdict != 0) begin
            push_ev(EV_DROP, p + 2, 4'hF);
            push_ev(EV_PFALL, p + 6, 4'hF);
            if (verdict == 1) m_bad++; else m_crc++;
            fin = p + 6;
        end else begin
            push_ev(EV_START, s, idx);
            if (reset_mid) begin
                fin = s;
            end else if (j >= 1 && j <= HDL_T) begin
                push_ev(EV_BFALL, s + j + 1, 4'hF);
                push_ev(EV_PFALL, s + j + 5, 4'hF);
                fin = s + j + 5;
            end else begin
                push_ev(EV_DROP, s + HDL_T + 1, 4'hF);
                push_ev(EV_BFALL, s + HDL_T + 1, 4'hF);
                push_ev(EV_PFALL, s + HDL_T + 5, 4'hF);
                m_hdl++;
                fin = s + HDL_T + 5;
            end
        end
        wait_until(p + 2);
        cmd_out = '0; cmd_complete = 1'b0; packet_complete = 1'b0;
        crc5invalid = 1'b0; crc16invalid = 1'b0;
        if (verdict == 0 && reset_mid) begin
            wait_until(s + 5);
            reset = 1'b1;
            q = cyc;
            push_ev(EV_BFALL, q + 1, 4'hF);
            push_ev(EV_PFALL, q + 2 + RSTC, 4'hF);
            m_crc = 0; m_rx = 0; m_hdl = 0; m_bad = 0;
            wait_until(q + 1);
            check("mid_reset_busy", int'(busy), 0);
            check("mid_reset_cmd_id", int'(cmd_id), 15);
            check("mid_reset_parser_reset", int'(parser_reset), 1);
            wait_until(q + 2);
            reset = 1'b0;
            fin = q + 2 + RSTC;
        end else if (verdict == 0 && j >= 1 && j <= HDL_T) begin
            wait_until(s + j);
            handler_done = 1'b1;
            wait_until(s + j + 1);
            handler_done = 1'b0;
        end
        next_free = fin + $urandom_range(0, 2);
    endtask

    task automatic check_stats();
`ifdef CMD_SEQ_STATS_EN
        check("crc_err_cnt", int'(crc_err_cnt), (m_crc > 255) ? 255 : m_crc);
        check("rx_to_cnt",   int'(rx_to_cnt),   (m_rx  > 255) ? 255 : m_rx);
        check("hdl_to_cnt",  int'(hdl_to_cnt),  (m_hdl > 255) ? 255 : m_hdl);
        check("bad_cmd_cnt", int'(bad_cmd_cnt), (m_bad > 255) ? 255 : m_bad);
`endif
    endtask

    initial begin
        logic [12:0] v;
        push_ev(EV_PFALL, 3 + RSTC, 4'hF);
        @(negedge clk);
        wait_until(1);
        check("reset_parser_reset", int'(parser_reset), 1);
        check("reset_handler_start", int'(handler_start), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_drop", int'(drop), 0);
        check("reset_cmd_id", int'(cmd_id), 15);
        check_stats();
        wait_until(3);
        reset = 1'b0;
        next_free = 3 + RSTC;

        send_packet(13'h0004, 1'b0, 1'b1, 2, 3, 1'b0);       // Query, crc16 ignored
        send_packet(13'h0004, 1'b1, 1'b0, 1, 3, 1'b0);       // Query, crc5 bad
        send_packet(13'h0003, 1'b0, 1'b0, 0, 3, 1'b0);       // two bits set
        send_packet(13'h0000, 1'b0, 1'b0, 3, 3, 1'b0);       // no bit set
        send_packet(13'h0010, 1'b0, 1'b1, 1, 3, 1'b0);       // Select, crc16 bad
        send_packet(13'h0020, 1'b1, 1'b1, 1, 2, 1'b0);       // Nak, flags ignored
        send_packet(13'h0001, 1'b0, 1'b0, RX_T + 1, 0, 1'b0); // rx timeout
        send_packet(13'h0001, 1'b0, 1'b0, RX_T, 2, 1'b0);     // pc in last rx cycle
        send_packet(13'h0080, 1'b0, 1'b0, 1, 0, 1'b0);       // Read, handler timeout
        send_packet(13'h0080, 1'b0, 1'b0, 1, HDL_T, 1'b0);   // done in timeout cycle
        send_packet(13'h1000, 1'b0, 1'b0, 0, 1, 1'b0);       // earliest done

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                v = '0;
                v[$urandom_range(0, 12)] = 1'b1;
            end else if (r < 80) begin
                v = '0;
            end else begin
                v = 13'($urandom);
                while ($countones(v) < 2) v = 13'($urandom);
            end
            send_packet(v, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                        int'($urandom_range(0, 4)), int'($urandom_range(1, 20)), 1'b0);
        end
        wait_until(next_free);
        check_stats();

        send_packet(13'h0800, 1'b0, 1'b0, 2, 0, 1'b1);       // reset during WAIT_DONE
        wait_until(next_free + 3);
        check_stats();
        send_packet(13'h0100, 1'b0, 1'b0, 1, 4, 1'b0);       // recovers after reset
        wait_until(next_free + 3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: cycle %0d, expected run to finish", cyc);
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
